prio_encoder_pipe: RTL
======================

PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 SHALL have parameter WIDTH_DATA_IN, default 32, request vector width; legal range >= 2.
REQ-002 SHALL have parameter WIDTH_IDX, default $clog2(WIDTH_DATA_IN), index width; not overridden.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request vector present.
REQ-006 SHALL have port in_ready  output  1  block can accept a vector this cycle.
REQ-007 SHALL have port in_data  input  WIDTH_DATA_IN  request vector.
REQ-008 SHALL have port in_mode  input  2  search mode: 0 LSB-first, 1 MSB-first, 2 round-robin, 3 LSB-first.
REQ-009 SHALL have port out_valid  output  1  result held.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_found  output  1  at least one bit set in the captured vector.
REQ-012 SHALL have port out_idx  output  WIDTH_IDX  index of the winning bit.
REQ-013 SHALL have port out_onehot  output  WIDTH_DATA_IN  one-hot of the winning bit.
REQ-014 SHALL have port out_count  output  WIDTH_IDX+1  number of set bits in the captured vector.

Function
REQ-015 SHALL accept a vector when in_valid && in_ready at a rising edge.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register, no bubble).
REQ-017 SHALL present all results of an accepted vector from the next cycle, 1-cycle latency, registered outputs.
REQ-018 SHALL set out_valid on acceptance and clear it when out_ready && !(in_valid && in_ready) at the same edge.
REQ-019 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-020 SHALL, on simultaneous output consume and input accept, replace the result with the new one; out_valid stays 1.
REQ-021 SHALL in mode 0/3 select the lowest-index set bit.
REQ-022 SHALL in mode 1 select the highest-index set bit.
REQ-023 SHALL in mode 2 search bits rr_ptr+1, rr_ptr+2, ... modulo WIDTH_DATA_IN, ending at rr_ptr; first set bit wins.
REQ-024 SHALL update rr_ptr to the winning index on acceptance only when mode is 2 and a bit is found; otherwise rr_ptr unchanged.
REQ-025 SHALL use the updated rr_ptr for the next accepted vector, including back-to-back acceptances.
REQ-026 SHALL, for an all-zero vector, produce out_found=0, out_idx=0, out_onehot=0, out_count=0, with no rr_ptr change.
REQ-027 SHALL compute out_count as the full popcount (WIDTH_DATA_IN all ones -> WIDTH_DATA_IN, no overflow).
REQ-028 SHALL sample in_mode with in_data; the mode never affects out_count.
REQ-029 SHALL ignore in_data and in_mode when no acceptance occurs.

Reset
REQ-030 SHALL, while rst=1, force out_valid=0, out_found=0, out_idx=0, out_onehot=0, out_count=0, rr_ptr=WIDTH_DATA_IN-1.
REQ-031 SHALL drive in_ready=1 during and after reset; a held result is discarded when reset asserts mid-operation.
REQ-032 SHALL make the first round-robin search after reset start at bit 0.

Verification (WIDTH_DATA_IN=8)
REQ-033 SHALL cover: rst pulse with out_valid=1 held -> next cycle out_valid=0, in_ready=1, all out_* zero.
REQ-034 SHALL cover: mode 0, in_data=8'b0110_1000 -> next cycle out_idx=3, out_onehot=8'b0000_1000, out_count=3, out_found=1; mode 1, same data -> out_idx=6, out_onehot=8'b0100_0000.
REQ-035 SHALL cover: mode 2, in_data=8'b1000_0101 four times back-to-back with out_ready=1 -> out_idx sequence 0, 2, 7, 0.
REQ-036 SHALL cover: in_data=0 in each mode -> out_found=0, out_idx=0, out_count=0; a following mode-2 vector 8'b0000_0001 after reset -> out_idx=0.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, first result stable, second vector not accepted; out_ready=1 -> second vector accepted in the same cycle, result next cycle.
REQ-038 SHALL cover: in_data=8'hFF, mode 1 -> out_idx=7, out_count=8.

Source files
------------

// File: rtl/prio_encoder_pipe.sv
// rtl/prio_encoder_pipe.sv - registered priority encoder with LSB/MSB/round-robin search and popcount
module prio_encoder_pipe #(
  parameter int WIDTH_DATA_IN = 32,
  parameter int WIDTH_IDX     = $clog2(WIDTH_DATA_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_DATA_IN-1:0] in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_found,
  output logic [WIDTH_IDX-1:0]     out_idx,
  output logic [WIDTH_DATA_IN-1:0] out_onehot,
  output logic [WIDTH_IDX:0]       out_count
);

  logic [WIDTH_IDX-1:0]     rr_ptr;
  logic [WIDTH_IDX-1:0]     lsb_idx;
  logic [WIDTH_IDX-1:0]     msb_idx;
  logic [WIDTH_IDX-1:0]     rr_idx;
  logic [WIDTH_IDX-1:0]     sel_idx;
  logic [WIDTH_DATA_IN-1:0] sel_onehot;
  logic [WIDTH_IDX:0]       count;
  logic                     found;
  logic                     rr_hit;
  logic                     accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign found    = |in_data;

  always_comb begin
    lsb_idx = '0;
    msb_idx = '0;
    rr_idx  = '0;
    rr_hit  = 1'b0;
    count   = '0;
    for (int i = WIDTH_DATA_IN - 1; i >= 0; i--) begin
      if (in_data[i]) lsb_idx = WIDTH_IDX'(i);
    end
    for (int i = 0; i < WIDTH_DATA_IN; i++) begin
      if (in_data[i]) msb_idx = WIDTH_IDX'(i);
      count = count + {{WIDTH_IDX{1'b0}}, in_data[i]};
    end
    // Walk rr_ptr+1 .. rr_ptr (wrapping); the first set bit wins.
    for (int k = 1; k <= WIDTH_DATA_IN; k++) begin
      int pos;
      pos = int'(rr_ptr) + k;
      if (pos >= WIDTH_DATA_IN) pos = pos - WIDTH_DATA_IN;
      if (!rr_hit && in_data[WIDTH_IDX'(pos)]) begin
        rr_hit = 1'b1;
        rr_idx = WIDTH_IDX'(pos);
      end
    end
  end

  always_comb begin
    case (in_mode)
      2'd1:    sel_idx = msb_idx;
      2'd2:    sel_idx = rr_idx;
      default: sel_idx = lsb_idx;
    endcase
    sel_onehot = found ? (WIDTH_DATA_IN'(1) << sel_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_found  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_count  <= '0;
      rr_ptr     <= WIDTH_IDX'(WIDTH_DATA_IN - 1);
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_found  <= found;
      out_idx    <= sel_idx;
      out_onehot <= sel_onehot;
      out_count  <= count;
      if (in_mode == 2'd2 && found) rr_ptr <= rr_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
